// File: rtl/usbf_tok_dec.sv
// usbf_tok_dec: USB token packet decoder between the UTMI receive byte stream
// and the protocol engine. Captures PID plus two token bytes, checks the PID
// check-nibble and the token CRC5, then reports the result as a one-cycle pulse.
//
// Ports:
//   clk, rst           core clock, asynchronous active-low reset
//   rx_data/rx_valid   UTMI receive byte and its qualifier
//   rx_active          packet in progress; its falling edge ends the packet
//   rx_err             UTMI receive error
//   pid                last PID whose check nibble was good
//   token_fadr/endp    address/endpoint of the last good OUT/IN/SETUP/PING
//   frame_no           frame number of the last good SOF
//   tok_valid, sof_valid, pid_err, crc5_err, seq_err
//                      one-cycle, mutually exclusive result pulses
//
// Latency: result pulse one clk after rx_active is sampled low in the check
// state; pid_err/seq_err pulse one clk after the offending byte or error.

// Combinational USB CRC5 over an 11-bit token field (parallel form of x^5+x^2+1).
module usbf_crc5 (
  input  logic [4:0]  crc_in,
  input  logic [10:0] din,
  output logic [4:0]  crc_out
);

  assign crc_out[0] = din[10] ^ din[9] ^ din[6] ^ din[5] ^ din[3] ^ din[0] ^
                      crc_in[0] ^ crc_in[3] ^ crc_in[4];
  assign crc_out[1] = din[10] ^ din[7] ^ din[6] ^ din[4] ^ din[1] ^
                      crc_in[0] ^ crc_in[1] ^ crc_in[4];
  assign crc_out[2] = din[10] ^ din[9] ^ din[8] ^ din[7] ^ din[6] ^ din[3] ^
                      din[2] ^ din[0] ^ crc_in[0] ^ crc_in[1] ^ crc_in[2] ^
                      crc_in[3] ^ crc_in[4];
  assign crc_out[3] = din[10] ^ din[9] ^ din[8] ^ din[7] ^ din[4] ^ din[3] ^
                      din[1] ^ crc_in[1] ^ crc_in[2] ^ crc_in[3] ^ crc_in[4];
  assign crc_out[4] = din[10] ^ din[9] ^ din[8] ^ din[5] ^ din[4] ^ din[2] ^
                      crc_in[2] ^ crc_in[3] ^ crc_in[4];

endmodule

module usbf_tok_dec (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_err,
  output logic [3:0]  pid,
  output logic [6:0]  token_fadr,
  output logic [3:0]  token_endp,
  output logic [10:0] frame_no,
  output logic        tok_valid,
  output logic        sof_valid,
  output logic        pid_err,
  output logic        crc5_err,
  output logic        seq_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PID   = 3'd1;
  localparam logic [2:0] ST_TOK0  = 3'd2;
  localparam logic [2:0] ST_TOK1  = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_PING  = 4'b0100;

  logic [2:0]  state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [6:0]  fadr_q, fadr_d;
  logic [3:0]  endp_q, endp_d;
  logic [10:0] frame_q, frame_d;
  logic        tok_valid_q, tok_valid_d;
  logic        sof_valid_q, sof_valid_d;
  logic        pid_err_q, pid_err_d;
  logic        crc5_err_q, crc5_err_d;
  logic        seq_err_q, seq_err_d;

  logic        pid_ok;
  logic        pid_is_token;
  logic [10:0] tok_field;
  logic [10:0] crc_din;
  logic [4:0]  crc_out;
  logic [4:0]  crc_expect;
  logic        crc_ok;

  // PID byte carries its own one's complement in the upper nibble.
  assign pid_ok = (rx_data[7:4] == ~rx_data[3:0]);

  always_comb begin
    case (rx_data[3:0])
      PID_OUT, PID_IN, PID_SETUP, PID_SOF, PID_PING: pid_is_token = 1'b1;
      default:                                       pid_is_token = 1'b0;
    endcase
  end

  // Token field is transmitted LSB first; the CRC core wants it MSB first.
  assign tok_field = {byte1_q[2:0], byte0_q};
  always_comb begin
    for (int i = 0; i < 11; i++) begin
      crc_din[10-i] = tok_field[i];
    end
  end

  usbf_crc5 u_crc5 (
    .crc_in  (5'h1F),
    .din     (crc_din),
    .crc_out (crc_out)
  );

  // Residue is inverted and sent MSB first, landing bit-reversed in byte1[7:3].
  assign crc_expect = ~{crc_out[0], crc_out[1], crc_out[2], crc_out[3], crc_out[4]};
  assign crc_ok     = (crc_expect == byte1_q[7:3]);

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    fadr_d      = fadr_q;
    endp_d      = endp_q;
    frame_d     = frame_q;
    tok_valid_d = 1'b0;
    sof_valid_d = 1'b0;
    pid_err_d   = 1'b0;
    crc5_err_d  = 1'b0;
    seq_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_active) state_d = ST_PID;
      end

      ST_PID: begin
        // No PID latched yet, so an early end of packet is silent here.
        if (rx_err) begin
          seq_err_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (!rx_active) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          if (!pid_ok) begin
            pid_err_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            pid_d   = rx_data[3:0];
            // Non-token packets belong to other engines: drain quietly.
            state_d = pid_is_token ? ST_TOK0 : ST_DRAIN;
          end
        end
      end

      ST_TOK0: begin
        if (rx_err) begin
          seq_err_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (!rx_active) begin
          seq_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (rx_valid) begin
          byte0_d = rx_data;
          state_d = ST_TOK1;
        end
      end

      ST_TOK1: begin
        if (rx_err) begin
          seq_err_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (!rx_active) begin
          seq_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (rx_valid) begin
          byte1_d = rx_data;
          state_d = ST_CHK;
        end
      end

      ST_CHK: begin
        if (rx_err) begin
          seq_err_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (!rx_active) begin
          state_d = ST_IDLE;
          if (!crc_ok) begin
            crc5_err_d = 1'b1;
          end else if (pid_q == PID_SOF) begin
            sof_valid_d = 1'b1;
            frame_d     = tok_field;
          end else begin
            tok_valid_d = 1'b1;
            fadr_d      = byte0_q[6:0];
            endp_d      = {byte1_q[2:0], byte0_q[7]};
          end
        end else if (rx_valid) begin
          // Token packets are exactly three bytes.
          seq_err_d = 1'b1;
          state_d   = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Already reported (or not ours): no further pulses for this packet,
        // including a late rx_err.
        if (!rx_active) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pid_q       <= 4'd0;
      byte0_q     <= 8'd0;
      byte1_q     <= 8'd0;
      fadr_q      <= 7'd0;
      endp_q      <= 4'd0;
      frame_q     <= 11'd0;
      tok_valid_q <= 1'b0;
      sof_valid_q <= 1'b0;
      pid_err_q   <= 1'b0;
      crc5_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      fadr_q      <= fadr_d;
      endp_q      <= endp_d;
      frame_q     <= frame_d;
      tok_valid_q <= tok_valid_d;
      sof_valid_q <= sof_valid_d;
      pid_err_q   <= pid_err_d;
      crc5_err_q  <= crc5_err_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign pid        = pid_q;
  assign token_fadr = fadr_q;
  assign token_endp = endp_q;
  assign frame_no   = frame_q;
  assign tok_valid  = tok_valid_q;
  assign sof_valid  = sof_valid_q;
  assign pid_err    = pid_err_q;
  assign crc5_err   = crc5_err_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_usbf_tok_dec.sv
// Testbench for usbf_tok_dec: packet-level reference model feeds a scoreboard
// queue; an independent monitor pops and compares on every result pulse.
module tb_usbf_tok_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_active;
  logic        rx_err;
  logic [3:0]  pid;
  logic [6:0]  token_fadr;
  logic [3:0]  token_endp;
  logic [10:0] frame_no;
  logic        tok_valid;
  logic        sof_valid;
  logic        pid_err;
  logic        crc5_err;
  logic        seq_err;

  usbf_tok_dec dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_active  (rx_active),
    .rx_err     (rx_err),
    .pid        (pid),
    .token_fadr (token_fadr),
    .token_endp (token_endp),
    .frame_no   (frame_no),
    .tok_valid  (tok_valid),
    .sof_valid  (sof_valid),
    .pid_err    (pid_err),
    .crc5_err   (crc5_err),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  localparam int K_TOK = 0;
  localparam int K_SOF = 1;
  localparam int K_PID = 2;
  localparam int K_CRC = 3;
  localparam int K_SEQ = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  pid;
    logic [6:0]  fadr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model of the decoder's visible registers.
  logic [3:0]  m_pid;
  logic [6:0]  m_fadr;
  logic [3:0]  m_endp;
  logic [10:0] m_frame;

  logic [7:0] pkt [0:5];

  // Serial USB CRC5 over the token field, LSB first, seed all ones; returns
  // the value that belongs in byte1[7:3] (inverted residue, sent MSB first).
  function automatic logic [4:0] crc5_field(input logic [10:0] f);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = f[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    c = ~c;
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

  function automatic bit is_tok_pid(input logic [3:0] p);
    return (p == 4'h1) || (p == 4'h9) || (p == 4'hD) || (p == 4'h5) || (p == 4'h4);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic push(input int kind);
    exp_t e;
    e.kind  = kind;
    e.cyc   = cyc + 1;
    e.pid   = m_pid;
    e.fadr  = m_fadr;
    e.endp  = m_endp;
    e.frame = m_frame;
    sbq.push_back(e);
  endtask

  task automatic set_pkt(input logic [7:0] b0, b1, b2, b3, b4, b5);
    pkt[0] = b0; pkt[1] = b1; pkt[2] = b2;
    pkt[3] = b3; pkt[4] = b4; pkt[5] = b5;
  endtask

  task automatic mk_tok(input logic [3:0] p, input logic [10:0] f);
    set_pkt({~p, p}, f[7:0], {crc5_field(f), f[10:8]}, 8'($urandom),
            8'($urandom), 8'($urandom));
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      @(negedge clk);
      rx_active = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'($urandom);
    end
  endtask

  // Sends pkt[0..n-1]; err_k >= 0 inserts an rx_err cycle before byte err_k.
  // The expected outcome follows the packet-level rules: first fault wins,
  // everything after it in the same packet is silent.
  task automatic send_pkt(input int n, input int err_k);
    bit done;
    bit good_pid;
    logic [10:0] f;
    done     = 1'b0;
    good_pid = (pkt[0][7:4] == ~pkt[0][3:0]);
    @(negedge clk);
    rx_active = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'($urandom);
    for (int k = 0; k <= n; k++) begin
      if (k == err_k) begin
        gap();
        @(negedge clk);
        rx_err = 1'b1; rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom);
        if (!done) begin
          push(K_SEQ);
          done = 1'b1;
        end
      end
      if (k < n) begin
        gap();
        @(negedge clk);
        rx_err = 1'b0; rx_valid = 1'b1; rx_data = pkt[k];
        if (!done) begin
          if (k == 0) begin
            if (!good_pid) begin
              push(K_PID);
              done = 1'b1;
            end else begin
              m_pid = pkt[0][3:0];
              if (!is_tok_pid(pkt[0][3:0])) done = 1'b1;
            end
          end else if (k == 3) begin
            push(K_SEQ);
            done = 1'b1;
          end
        end
      end
    end
    gap();
    @(negedge clk);
    rx_active = 1'b0; rx_valid = 1'b0; rx_err = 1'b0;
    if (!done && n > 0) begin
      if (n < 3) begin
        push(K_SEQ);
      end else begin
        f = {pkt[2][2:0], pkt[1]};
        if (crc5_field(f) != pkt[2][7:3]) begin
          push(K_CRC);
        end else if (pkt[0][3:0] == 4'h5) begin
          m_frame = f;
          push(K_SOF);
        end else begin
          m_fadr = f[6:0];
          m_endp = f[10:7];
          push(K_TOK);
        end
      end
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'($urandom);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compares every pulse against the head of the scoreboard and
  // flags any expected pulse whose cycle passes without it.
  always @(posedge clk) begin
    logic [4:0] pulses;
    logic [4:0] want;
    exp_t e;
    #1;
    cyc++;
    pulses = {tok_valid, sof_valid, pid_err, crc5_err, seq_err};
    if (pulses != 5'd0) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got pulses=%b at cyc %0d want none", pulses, cyc);
      end else begin
        e    = sbq.pop_front();
        want = 5'b10000 >> e.kind;
        check("pulse_kind_and_time", {27'd0, pulses, 32'(cyc)}, {27'd0, want, 32'(e.cyc)});
        check("fields_at_pulse", {33'd0, pid, token_fadr, token_endp, frame_no},
              {33'd0, e.pid, e.fadr, e.endp, e.frame});
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pulse: got none at cyc %0d want kind %0d", cyc, e.kind);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, n, ek;
    logic [3:0]  p;
    logic [10:0] f;
    logic [3:0]  nontok [0:3];
    nontok[0] = 4'h3; nontok[1] = 4'hB; nontok[2] = 4'h2; nontok[3] = 4'hA;

    rst = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; rx_active = 1'b0; rx_err = 1'b0;
    m_pid = 4'd0; m_fadr = 7'd0; m_endp = 4'd0; m_frame = 11'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {33'd0, pid, token_fadr, token_endp, frame_no, tok_valid,
          sof_valid, pid_err, crc5_err, seq_err}, 64'd0);
    rst = 1'b1;
    settle();

    // SETUP addr 0 ep 0, good CRC
    set_pkt(8'h2D, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00); send_pkt(3, -1); settle();
    // Same with corrupted CRC
    set_pkt(8'h2D, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00); send_pkt(3, -1); settle();
    // Bad PID check nibble
    set_pkt(8'h2C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00); send_pkt(3, -1); settle();
    // Short and long OUT
    set_pkt(8'hE1, 8'h00, 8'h10, 8'h55, 8'h00, 8'h00); send_pkt(2, -1); settle();
    send_pkt(4, -1); settle();
    // DATA0 with payload, then a normal SETUP
    set_pkt(8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55); send_pkt(6, -1); settle();
    set_pkt(8'h2D, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00); send_pkt(3, -1); settle();
    // rx_err during byte1 of a SETUP
    send_pkt(3, 2); settle();
    // Good OUT with nonzero fields, then SOF, so the reset below is visible
    mk_tok(4'h1, {4'd3, 7'h15}); send_pkt(3, -1); settle();
    mk_tok(4'h5, 11'h5A3); send_pkt(3, -1); settle();

    // Async reset mid-token
    @(negedge clk); rx_active = 1'b1; rx_valid = 1'b0;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h2D;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h00;
    #2 rst = 1'b0;
    #1 check("midpacket_reset_outputs", {33'd0, pid, token_fadr, token_endp, frame_no,
             tok_valid, sof_valid, pid_err, crc5_err, seq_err}, 64'd0);
    m_pid = 4'd0; m_fadr = 7'd0; m_endp = 4'd0; m_frame = 11'd0;
    @(negedge clk); rx_active = 1'b0; rx_valid = 1'b0;
    rst = 1'b1;
    settle();
    mk_tok(4'h9, {4'd7, 7'h7F}); send_pkt(3, -1); settle();

    // Randomized packets
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      f   = 11'($urandom);
      if (sel <= 6) begin
        case ($urandom_range(0, 4))
          0: p = 4'h1;
          1: p = 4'h9;
          2: p = 4'hD;
          3: p = 4'h5;
          default: p = 4'h4;
        endcase
        mk_tok(p, f);
        if ($urandom_range(0, 4) == 0) pkt[2][7:3] = pkt[2][7:3] ^ (5'd1 << $urandom_range(0, 4));
      end else if (sel == 7) begin
        p = nontok[$urandom_range(0, 3)];
        mk_tok(p, f);
      end else begin
        mk_tok(4'h1, f);
        pkt[0] = 8'($urandom);
      end
      n  = ($urandom_range(0, 9) < 7) ? 3 : $urandom_range(0, 5);
      ek = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n) : -1;
      send_pkt(n, ek);
    end
    settle();
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usbf_tok_dec.md
Name: usbf_tok_dec

Overview:
- Token packet decoder. Sits between the UTMI receive byte stream and the protocol engine.
- Captures PID plus two token bytes and checks PID integrity.
- Drives the combinational usbf_crc5 instance with the 11-bit token field and checks the received CRC5.
- Issues one-cycle valid pulses carrying decoded address/endpoint (OUT/IN/SETUP/PING) or frame number (SOF).

Parameters:
- none (all widths fixed by USB 2.0 token format)

Ports:
- clk  input  1  core clock; all state on rising edge
- rst  input  1  asynchronous active-low reset
- rx_data  input  8  UTMI receive byte
- rx_valid  input  1  rx_data valid this cycle
- rx_active  input  1  packet in progress; falling edge = end of packet
- rx_err  input  1  UTMI receive error
- pid  output  4  captured PID[3:0]
- token_fadr  output  7  function address (token byte0[6:0])
- token_endp  output  4  endpoint ({byte1[2:0], byte0[7]})
- frame_no  output  11  SOF frame number ({byte1[2:0], byte0})
- tok_valid  output  1  one-cycle pulse: good OUT/IN/SETUP/PING token
- sof_valid  output  1  one-cycle pulse: good SOF
- pid_err  output  1  one-cycle pulse: PID check-nibble mismatch
- crc5_err  output  1  one-cycle pulse: CRC5 mismatch
- seq_err  output  1  one-cycle pulse: wrong byte count or rx_err

Behaviour:
- Reset: state IDLE. pid, token_fadr, token_endp, frame_no = 0. All pulse outputs = 0. Byte regs cleared.
- States:
  - IDLE -> PID on rx_active=1.
  - PID: first rx_valid byte b. If b[7:4] != ~b[3:0], pulse pid_err and go to DRAIN. Otherwise latch pid=b[3:0].
    - Token PIDs (OUT 0001, IN 1001, SETUP 1101, SOF 0101, PING 0100) -> TOK0.
    - Any other PID -> DRAIN silently; it is not owned here.
  - TOK0: rx_valid byte -> byte0 reg -> TOK1.
  - TOK1: rx_valid byte -> byte1 reg -> CHK.
  - CHK: a further rx_valid byte while rx_active=1 pulses seq_err and goes to DRAIN. On rx_active=0, evaluate CRC, emit result, go to IDLE.
  - DRAIN: wait for rx_active=0, then go to IDLE; no pulses.
- rx_active falling in PID/TOK0/TOK1 (short packet): pulse seq_err if a valid PID was latched, then go to IDLE.
- rx_err=1 in any non-IDLE state: pulse seq_err once, go to DRAIN. rx_err outranks a simultaneous rx_valid byte.
- CRC check:
  - field[10:0] = {byte1[2:0], byte0}.
  - usbf_crc5 gets crc_in=5'h1F and din[10-i]=field[i] (bit-reversed).
  - Expected = ~{crc_out[0],crc_out[1],crc_out[2],crc_out[3],crc_out[4]}.
  - Pass iff Expected == byte1[7:3].
- Result cycle (the cycle after rx_active is sampled low in CHK):
  - On pass: SOF pulses sof_valid and updates frame_no. Other token PIDs pulse tok_valid and update token_fadr/token_endp.
  - On fail: pulse crc5_err only. Decoded fields hold their previous values.
- Latency: exactly one clk from sampled rx_active=0 to the pulse. Pulses are mutually exclusive and never wider than one cycle.
- Field outputs change only on a good token/SOF. pid updates on every check-passing PID byte.
- rx_valid=0 cycles inside a packet are ignored (no timeout here).
- Async reset mid-packet: return to IDLE immediately, no pulse. If rx_active is still 1 after reset release, enter PID and treat the next byte as a PID; a resulting error is acceptable.

Test Plan:
- SETUP 0x2D,0x00,0x10 then rx_active low -> tok_valid=1 for one cycle one clk later; pid=4'hD, token_fadr=0, token_endp=0; no error pulses.
- Same packet with last byte 0x18 -> crc5_err pulse; tok_valid stays 0; fields unchanged from the prior value.
- PID byte 0x2C (nibble mismatch) -> pid_err pulse; later bytes ignored until rx_active low; no other pulses.
- OUT 0xE1,0x00 then rx_active low -> seq_err pulse, no tok_valid. Separately, 4-byte OUT 0xE1,0x00,0x10,0x55 -> seq_err on the 4th byte.
- DATA0 0xC3 plus payload -> no pulses at all; decoder back in IDLE after rx_active low and accepts a following SETUP normally.
- rx_err asserted during byte1 of a SETUP -> single seq_err. Async rst low mid-token -> all outputs 0 immediately; next good token decodes correctly.
